// File: rtl/imem_stream_loader_if.sv
// Byte-stream input and instruction-memory write side of the boot loader.
// The master modport is the loader; the slave modport is the stream source / memory / core.
interface imem_stream_loader_if #(
  parameter int ADDR_W = 8
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_address;
  logic [31:0]       im_d;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;
  logic [15:0]       words_loaded;

  modport master (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output im_we,
    output im_address,
    output im_d,
    output cpu_hold,
    output load_done,
    output load_err,
    output words_loaded
  );

  modport slave (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  im_we,
    input  im_address,
    input  im_d,
    input  cpu_hold,
    input  load_done,
    input  load_err,
    input  words_loaded
  );
endinterface

// File: rtl/imem_stream_loader.sv
// Boot-time instruction memory writer: frames a byte stream as
// {len[15:0], len x 32-bit words MSB first, xor checksum} and releases the core when it verifies.
module imem_stream_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  imem_stream_loader_if.master bus
);

  localparam logic [2:0] S_LEN_HI = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_CSUM   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  // A length above the address space would silently wrap the write address.
  if ((DEPTH > (2 ** ADDR_W)) || (ADDR_W > 16) || (DEPTH < 1)) begin : g_cfg_err
    $error("imem_stream_loader: DEPTH must be 1..2**ADDR_W and ADDR_W <= 16");
  end

  logic [2:0]        state_q;
  logic [2:0]        state_nxt;
  logic [15:0]       len_q;
  logic [15:0]       len_cand;
  logic [1:0]        idx_q;
  logic [7:0]        csum_q;
  logic [23:0]       word_p0;
  logic [15:0]       words_loaded_q;
  logic              byte_ready_q;
  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [31:0]       data_p1;
  logic              cpu_hold_q;
  logic              load_done_q;
  logic              load_err_q;
  logic              accept;
  logic              last_word;

  assign accept    = bus.byte_valid & byte_ready_q;
  assign len_cand  = {len_q[15:8], bus.byte_data};
  assign last_word = (words_loaded_q + 16'd1) == len_q;

  always_comb begin
    state_nxt = state_q;
    if (accept) begin
      case (state_q)
        S_LEN_HI: state_nxt = S_LEN_LO;
        S_LEN_LO: begin
          if ({1'b0, len_cand} > DEPTH_L) state_nxt = S_ERR;
          else if (len_cand == 16'd0)     state_nxt = S_CSUM;
          else                            state_nxt = S_DATA;
        end
        S_DATA:   if ((idx_q == 2'd3) && last_word) state_nxt = S_CSUM;
        S_CSUM:   state_nxt = (bus.byte_data == csum_q) ? S_DONE : S_ERR;
        default:  state_nxt = state_q;
      endcase
    end
  end

  // p0: framing state, length capture, checksum and byte index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_LEN_HI;
      len_q        <= 16'd0;
      idx_q        <= 2'd0;
      csum_q       <= 8'd0;
      byte_ready_q <= 1'b0;
      cpu_hold_q   <= 1'b1;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      byte_ready_q <= (state_nxt != S_DONE) && (state_nxt != S_ERR);
      cpu_hold_q   <= (state_nxt != S_DONE);
      load_done_q  <= (state_nxt == S_DONE);
      load_err_q   <= (state_nxt == S_ERR);
      if (accept) begin
        case (state_q)
          S_LEN_HI: len_q[15:8] <= bus.byte_data;
          S_LEN_LO: len_q[7:0]  <= bus.byte_data;
          S_DATA: begin
            csum_q <= csum_q ^ bus.byte_data;
            idx_q  <= idx_q + 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // Partial word only needs the three earlier bytes; the fourth goes straight to the write.
  always_ff @(posedge clk) begin
    if (accept && (state_q == S_DATA)) begin
      word_p0 <= {word_p0[15:0], bus.byte_data};
    end
  end

  // p1: one-cycle memory write strobe with its address and data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1         <= 1'b0;
      addr_p1        <= '0;
      data_p1        <= 32'd0;
      words_loaded_q <= 16'd0;
    end else begin
      vld_p1 <= 1'b0;
      if (accept && (state_q == S_DATA) && (idx_q == 2'd3)) begin
        vld_p1         <= 1'b1;
        addr_p1        <= words_loaded_q[ADDR_W-1:0];
        data_p1        <= {word_p0, bus.byte_data};
        words_loaded_q <= words_loaded_q + 16'd1;
      end
    end
  end

  assign bus.byte_ready   = byte_ready_q;
  assign bus.im_we        = vld_p1;
  assign bus.im_address   = addr_p1;
  assign bus.im_d         = data_p1;
  assign bus.cpu_hold     = cpu_hold_q;
  assign bus.load_done    = load_done_q;
  assign bus.load_err     = load_err_q;
  assign bus.words_loaded = words_loaded_q;

endmodule
